// File: rtl/digital_clock.sv
// -----------------------------------------------------------------------------
// digital_clock
//
// Free-running 24-hour time-of-day counter (HH:MM:SS, plain binary).
// A prescaler divides clk down to a one-cycle tick. Each tick advances the
// seconds counter, and its carry ripples into minutes and then hours within
// the same edge. All outputs come straight from registers.
//
// Parameters:
//   CLK_FREQ_HZ   input clock frequency in Hz
//   TICK_FREQ_HZ  seconds-tick rate in Hz; DIV = CLK_FREQ_HZ / TICK_FREQ_HZ
//                 (integer division, DIV >= 1)
//   SEC_VALUE     seconds modulus (out_sec counts 0..SEC_VALUE-1)
//   MIN_VALUE     minutes modulus (out_min counts 0..MIN_VALUE-1)
//   HOUR_VALUE    hours modulus   (out_hour counts 0..HOUR_VALUE-1)
//
// Ports:
//   clk       in   system clock, rising-edge active
//   reset     in   asynchronous active-low reset; clears prescaler and time
//   out_sec   out  current seconds
//   out_min   out  current minutes
//   out_hour  out  current hours
//
// Optional feature, macro DIGITAL_CLOCK_SET_EN:
//   set_en    in   load request; loads set_* and clears the prescaler.
//                  Beats the tick; reset beats set_en.
//   set_hour  in   hour load value   (clamped to HOUR_VALUE-1)
//   set_min   in   minute load value (clamped to MIN_VALUE-1)
//   set_sec   in   second load value (clamped to SEC_VALUE-1)
//   With the macro undefined the time can only be cleared by reset.
// -----------------------------------------------------------------------------
module digital_clock #(
  parameter int CLK_FREQ_HZ  = 50_000,
  parameter int TICK_FREQ_HZ = 1,
  parameter int SEC_VALUE    = 60,
  parameter int MIN_VALUE    = 60,
  parameter int HOUR_VALUE   = 24
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef DIGITAL_CLOCK_SET_EN
  input  logic                          set_en,
  input  logic [$clog2(HOUR_VALUE)-1:0] set_hour,
  input  logic [$clog2(MIN_VALUE)-1:0]  set_min,
  input  logic [$clog2(SEC_VALUE)-1:0]  set_sec,
`endif
  output logic [$clog2(SEC_VALUE)-1:0]  out_sec,
  output logic [$clog2(MIN_VALUE)-1:0]  out_min,
  output logic [$clog2(HOUR_VALUE)-1:0] out_hour
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int DIV = CLK_FREQ_HZ / TICK_FREQ_HZ;
  // A divider of 1 still needs a 1-bit register to exist; it simply stays 0.
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(SEC_VALUE);
  localparam int MW  = $clog2(MIN_VALUE);
  localparam int HW  = $clog2(HOUR_VALUE);

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_VALUE - 1);
  localparam logic [MW-1:0] MIN_MAX   = MW'(MIN_VALUE - 1);
  localparam logic [HW-1:0] HOUR_MAX  = HW'(HOUR_VALUE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q,   sec_d;
  logic [MW-1:0] min_q,   min_d;
  logic [HW-1:0] hour_q,  hour_d;

  logic tick;
  logic min_carry;
  logic hour_carry;

  // ---------------------------------------------------------------------------
  // Tick and carry chain. Carries are combinational so that a rollover such as
  // 23:59:59 -> 00:00:00 updates every field on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    min_carry  = tick      && (sec_q == SEC_MAX);
    hour_carry = min_carry && (min_q == MIN_MAX);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; any path that left
    // one unassigned would make synthesis infer a latch to hold its old value.
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;

    // The ">=" comparisons make an out-of-range value (only reachable by
    // forcing) wrap to 0 on its next increment instead of counting on.
    presc_d = (presc_q >= PRESC_MAX) ? '0 : presc_q + 1'b1;

    if (tick) begin
      sec_d = (sec_q >= SEC_MAX) ? '0 : sec_q + 1'b1;
    end

    if (min_carry) begin
      min_d = (min_q >= MIN_MAX) ? '0 : min_q + 1'b1;
    end

    if (hour_carry) begin
      hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 1'b1;
    end

`ifdef DIGITAL_CLOCK_SET_EN
    // A load overrides whatever the tick would have done this edge and
    // restarts the prescaler so the loaded second lasts a full period.
    if (set_en) begin
      presc_d = '0;
      sec_d   = (set_sec  > SEC_MAX)  ? SEC_MAX  : set_sec;
      min_d   = (set_min  > MIN_MAX)  ? MIN_MAX  : set_min;
      hour_d  = (set_hour > HOUR_MAX) ? HOUR_MAX : set_hour;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  // Outputs are the registers themselves: glitch-free by construction.
  assign out_sec  = sec_q;
  assign out_min  = min_q;
  assign out_hour = hour_q;

endmodule

// File: tb/tb_digital_clock.sv
// -----------------------------------------------------------------------------
// tb_digital_clock
//
// Drives several digital_clock instances with different dividers and moduli
// from one clock and one reset. A time-of-day model derived from the number
// of clock edges since reset release is compared against every instance on
// each falling edge; directed literal checks pin the model at key instants.
// -----------------------------------------------------------------------------
module tb_digital_clock;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;
  bit cmp_en;

  // Rising edges seen since the last reset release; cleared by reset.
  longint edges;

  // DIV=4 instance, default moduli.
  logic [5:0] d4_sec,  d4_min;
  logic [4:0] d4_hour;
  // DIV=1 instance, default moduli.
  logic [5:0] d1_sec,  d1_min;
  logic [4:0] d1_hour;
  // DIV=1, small moduli 5/4/3 (60-edge day).
  logic [2:0] sm_sec;
  logic [1:0] sm_min;
  logic [1:0] sm_hour;
  // DIV=7/2=3 instance, default moduli.
  logic [5:0] d3_sec,  d3_min;
  logic [4:0] d3_hour;
  // All-default instance (DIV=50_000).
  logic [5:0] df_sec,  df_min;
  logic [4:0] df_hour;

`ifdef DIGITAL_CLOCK_SET_EN
  logic       set_en;
  logic [4:0] set_hour5;
  logic [5:0] set_min6, set_sec6;
  logic [1:0] set_hour2, set_min2;
  logic [2:0] set_sec3;
  initial begin
    set_en = 1'b0; set_hour5 = '0; set_min6 = '0; set_sec6 = '0;
    set_hour2 = '0; set_min2 = '0; set_sec3 = '0;
  end
`define SET6 .set_en(set_en), .set_hour(set_hour5), .set_min(set_min6), .set_sec(set_sec6),
`define SETS .set_en(set_en), .set_hour(set_hour2), .set_min(set_min2), .set_sec(set_sec3),
`else
`define SET6
`define SETS
`endif

  digital_clock #(.CLK_FREQ_HZ(4), .TICK_FREQ_HZ(1)) u_d4 (
    .clk(clk), .reset(reset), `SET6
    .out_sec(d4_sec), .out_min(d4_min), .out_hour(d4_hour));

  digital_clock #(.CLK_FREQ_HZ(1), .TICK_FREQ_HZ(1)) u_d1 (
    .clk(clk), .reset(reset), `SET6
    .out_sec(d1_sec), .out_min(d1_min), .out_hour(d1_hour));

  digital_clock #(.CLK_FREQ_HZ(1), .TICK_FREQ_HZ(1),
                  .SEC_VALUE(5), .MIN_VALUE(4), .HOUR_VALUE(3)) u_sm (
    .clk(clk), .reset(reset), `SETS
    .out_sec(sm_sec), .out_min(sm_min), .out_hour(sm_hour));

  digital_clock #(.CLK_FREQ_HZ(7), .TICK_FREQ_HZ(2)) u_d3 (
    .clk(clk), .reset(reset), `SET6
    .out_sec(d3_sec), .out_min(d3_min), .out_hour(d3_hour));

  digital_clock u_df (
    .clk(clk), .reset(reset), `SET6
    .out_sec(df_sec), .out_min(df_min), .out_hour(df_hour));

  // ---------------------------------------------------------------------------
  // Clock: period 10, rising edges at 5, 15, 25, ...
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model: elapsed seconds = edges / DIV, then split by the moduli.
  // ---------------------------------------------------------------------------
  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic longint pk(input longint h, input longint m, input longint s);
    return h * 65536 + m * 256 + s;
  endfunction

  function automatic longint model(input longint n, input longint div,
                                   input longint sv, input longint mv,
                                   input longint hv);
    longint t;
    t = n / div;
    return pk((t / (sv * mv)) % hv, (t / sv) % mv, t % sv);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, edges=%0d)",
               name, act, exp, $time, edges);
    end
  endtask

  // One compare process: every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_div4", pk(d4_hour, d4_min, d4_sec), model(edges, 4 / 1, 60, 60, 24));
      check("cmp_div1", pk(d1_hour, d1_min, d1_sec), model(edges, 1 / 1, 60, 60, 24));
      check("cmp_small", pk(sm_hour, sm_min, sm_sec), model(edges, 1 / 1, 5, 4, 3));
      check("cmp_div3", pk(d3_hour, d3_min, d3_sec), model(edges, 7 / 2, 60, 60, 24));
      check("cmp_default", pk(df_hour, df_min, df_sec), model(edges, 50000 / 1, 60, 60, 24));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    reset    = 1'b0;

    // Held in reset for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("reset_hold_div4",    pk(d4_hour, d4_min, d4_sec), 0);
    check("reset_hold_default", pk(df_hour, df_min, df_sec), 0);

    // Release on a falling edge so the next rising edge is edge 1.
    @(negedge clk);
    reset = 1'b1;

    // DIV=4: out_sec stays 0 through edge 3, 1 at edge 4, 2 at edge 8.
    repeat (3) @(posedge clk);
    #1 check("div4_edge3_sec", d4_sec, 0);
    @(posedge clk);
    #1 check("div4_edge4_sec", d4_sec, 1);
    repeat (4) @(posedge clk);
    #1 check("div4_edge8_sec", d4_sec, 2);

    // Run to 00:00:07 on the DIV=4 instance (edge 28).
    repeat (20) @(posedge clk);
    #1 check("div4_edge28_time", pk(d4_hour, d4_min, d4_sec), pk(0, 0, 7));

    // Asynchronous reset mid-count, between clock edges.
    #2 reset = 1'b0;
    #1;
    check("async_reset_div4",  pk(d4_hour, d4_min, d4_sec), 0);
    check("async_reset_div1",  pk(d1_hour, d1_min, d1_sec), 0);
    check("async_reset_small", pk(sm_hour, sm_min, sm_sec), 0);
    check("async_reset_div3",  pk(d3_hour, d3_min, d3_sec), 0);

    repeat (5) @(negedge clk);
    reset = 1'b1;

    // Seconds -> minutes carry (DIV=1) and small-moduli day rollover.
    repeat (59) @(posedge clk);
    #1;
    check("div1_edge59",  pk(d1_hour, d1_min, d1_sec), pk(0, 0, 59));
    check("small_edge59", pk(sm_hour, sm_min, sm_sec), pk(2, 3, 4));
    @(posedge clk);
    #1;
    check("div1_edge60",  pk(d1_hour, d1_min, d1_sec), pk(0, 1, 0));
    check("small_edge60", pk(sm_hour, sm_min, sm_sec), pk(0, 0, 0));

    // Minutes -> hours carry.
    repeat (3539) @(posedge clk);
    #1 check("div1_edge3599", pk(d1_hour, d1_min, d1_sec), pk(0, 59, 59));
    @(posedge clk);
    #1;
    check("div1_edge3600", pk(d1_hour, d1_min, d1_sec), pk(1, 0, 0));
    check("div4_edge3600", pk(d4_hour, d4_min, d4_sec), pk(0, 15, 0));

    // Default divider: first second at edge 50_000.
    repeat (46399) @(posedge clk);
    #1 check("default_edge49999", pk(df_hour, df_min, df_sec), 0);
    @(posedge clk);
    #1;
    check("default_edge50000", pk(df_hour, df_min, df_sec), pk(0, 0, 1));
    check("div1_edge50000",    pk(d1_hour, d1_min, d1_sec), pk(13, 53, 20));
    check("div3_edge50000",    pk(d3_hour, d3_min, d3_sec), pk(4, 37, 46));

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
